run_sequencer: RTL and testbench

Host-side run controller that sits directly upstream of the CPU core's `clk`/`reset`/`req`/`done` interface. It turns a single host `start` pulse into a clean core reset followed by a one-cycle `req`. It then waits for `done`, measures execution length in cycles, and reports completion (optionally with a watchdog timeout). It is the block the testbench and any future host wrapper drive instead of toggling core pins by hand.

---
 rtl/run_seq_pkg.sv | 21 ++
 rtl/sat_counter.sv | 24 ++
 rtl/run_sequencer.sv | 125 ++++++++++++
 tb/tb_run_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
package run_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StResetCore,
        StRequest,
        StRun,
        StFinish
    } run_state_t;

    localparam int unsigned DefaultResetCycles     = 2;
    localparam int unsigned DefaultCycleCountWidth = 16;
    localparam int unsigned DefaultTimeoutCycles   = 50000;

    // Bits needed to hold a down-count starting at cycles-1.
    function automatic int unsigned down_cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Host run controller: start -> core reset -> one-cycle req -> wait for done, counting RUN cycles.
// Define RUN_SEQ_TIMEOUT_EN to enable the RUN-state watchdog (timed_out); otherwise it stays 0.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES      = DefaultResetCycles,
    parameter int unsigned CYCLE_COUNT_WIDTH = DefaultCycleCountWidth,
    parameter int unsigned TIMEOUT_CYCLES    = DefaultTimeoutCycles
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         core_reset,
    output logic                         core_req,
    input  logic                         core_done,
    output logic                         busy,
    output logic                         finished,
    output logic                         timed_out,
    output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned RstCntW = down_cnt_width(RESET_CYCLES);
    localparam logic [RstCntW-1:0] RstCntLoad = RstCntW'(RESET_CYCLES - 1);
    localparam logic [CYCLE_COUNT_WIDTH-1:0] TimeoutLast =
        CYCLE_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef RUN_SEQ_TIMEOUT_EN
    localparam bit WatchdogEn = 1'b1;
`else
    localparam bit WatchdogEn = 1'b0;
`endif

    run_state_t       state_q;
    logic [RstCntW-1:0] rst_cnt_q;
    logic             core_reset_q;
    logic             core_req_q;
    logic             busy_q;
    logic             finished_q;
    logic             timed_out_q;

    logic             count_clr;
    logic             count_en;
    logic             wdog_expire;

    assign count_clr   = (state_q == StIdle) && start;
    assign count_en    = (state_q == StRun) && !core_done;
    // Constant-false when the watchdog is compiled out, so no comparator remains.
    assign wdog_expire = WatchdogEn && (cycle_count == TimeoutLast);

    sat_counter #(
        .WIDTH (CYCLE_COUNT_WIDTH)
    ) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (count_clr),
        .enable (count_en),
        .count  (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rst_cnt_q    <= '0;
            core_reset_q <= 1'b1;
            core_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            finished_q   <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            core_req_q <= 1'b0;
            finished_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StResetCore;
                        rst_cnt_q    <= RstCntLoad;
                        core_reset_q <= 1'b1;
                        busy_q       <= 1'b1;
                        timed_out_q  <= 1'b0;
                    end
                end
                StResetCore: begin
                    if (rst_cnt_q == '0) begin
                        state_q      <= StRequest;
                        core_reset_q <= 1'b0;
                        core_req_q   <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RstCntW'(1);
                    end
                end
                StRequest: begin
                    state_q <= StRun;
                end
                StRun: begin
                    // done takes precedence over a coincident watchdog expiry
                    if (core_done) begin
                        state_q    <= StFinish;
                        finished_q <= 1'b1;
                    end else if (wdog_expire) begin
                        state_q     <= StFinish;
                        finished_q  <= 1'b1;
                        timed_out_q <= 1'b1;
                    end
                end
                StFinish: begin
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                    core_reset_q <= 1'b1;
                end
                default: begin
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                    core_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign core_reset = core_reset_q;
    assign core_req   = core_req_q;
    assign busy       = busy_q;
    assign finished   = finished_q;
    assign timed_out  = timed_out_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer; expectations come from run-level timing rules.
module tb_run_sequencer;

    localparam int unsigned RC = 2;
    localparam int unsigned W  = 16;
    localparam int unsigned TO = 20;

`ifdef RUN_SEQ_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         core_done = 1'b0;
    logic         core_reset;
    logic         core_req;
    logic         busy;
    logic         finished;
    logic         timed_out;
    logic [W-1:0] cycle_count;

    typedef struct {
        int cyc;
        int count;
        int to;
    } result_t;

    int      req_q[$];
    result_t res_q[$];
    result_t mon_r;
    int      n_cmp = 0;
    int      n_fail = 0;
    int      cyc = 0;

    run_sequencer #(
        .RESET_CYCLES      (RC),
        .CYCLE_COUNT_WIDTH (W),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_reset  (core_reset),
        .core_req    (core_req),
        .core_done   (core_done),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, int'(core_reset), 1);
        check({tag, "_core_req"}, int'(core_req), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_finished"}, int'(finished), 0);
        check({tag, "_timed_out"}, int'(timed_out), 0);
        check({tag, "_cycle_count"}, int'(cycle_count), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a req or finished pulse.
    always @(negedge clk) begin
        if (core_req) begin
            if (req_q.size() == 0) check("core_req_unexpected", int'(core_req), 0);
            else check("core_req_cycle", cyc, req_q.pop_front());
        end
        if (finished) begin
            if (res_q.size() == 0) begin
                check("finished_unexpected", int'(finished), 0);
            end else begin
                mon_r = res_q.pop_front();
                check("finished_cycle", cyc, mon_r.cyc);
                check("cycle_count", int'(cycle_count), mon_r.count);
                check("timed_out_at_finish", int'(timed_out), mon_r.to);
            end
        end
    end

    // One run: done raised in RUN cycle d (1-based); cycle m counts from the cycle after start.
    task automatic run_once(input int d, input bit stale, input bit mid_start, input int rst_at);
        int      fin;
        int      cnt;
        int      tov;
        int      c0;
        int      n;
        result_t e;
        if (WD && d > int'(TO)) begin
            fin = RC + TO + 2;
            cnt = TO;
            tov = 1;
        end else begin
            fin = RC + d + 2;
            cnt = d - 1;
            tov = 0;
        end
        @(negedge clk);
        c0 = cyc;
        start = 1'b1;
        core_done = stale;
        req_q.push_back(c0 + RC + 1);
        if (rst_at == 0) begin
            e.cyc = c0 + fin;
            e.count = cnt;
            e.to = tov;
            res_q.push_back(e);
        end
        for (int m = 1; m <= fin + 1; m++) begin
            @(negedge clk);
            n = m - RC - 1;
            start = mid_start && (n == 5);
            core_done = (stale && n <= 0) || (n == d);
            check("core_reset", int'(core_reset), (m <= int'(RC) || m > fin) ? 1 : 0);
            check("busy", int'(busy), (m <= fin) ? 1 : 0);
            check("timed_out", int'(timed_out), (m >= fin) ? tov : 0);
            if (rst_at != 0 && n == rst_at) begin
                reset = 1'b1;
                start = 1'b0;
                core_done = 1'b0;
                @(negedge clk);
                check_reset_values("midrun_reset");
                reset = 1'b0;
                return;
            end
        end
        start = 1'b0;
        core_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int d;
        bit st;
        bit ms;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        // reset beats start at the same edge
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", int'(busy), 0);
        check("rst_prio_core_reset", int'(core_reset), 1);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_prio_idle_busy", int'(busy), 0);

        run_once(11, 1'b0, 1'b0, 0);
        run_once(1, 1'b1, 1'b0, 0);
        run_once(11, 1'b0, 1'b1, 0);
        run_once(WD ? 1000 : 25, 1'b0, 1'b0, 0);
        run_once(7, 1'b0, 1'b0, 0);
        run_once(TO, 1'b0, 1'b0, 0);
        run_once(TO + 1, 1'b1, 1'b0, 0);
        run_once(12, 1'b0, 1'b0, 4);
        run_once(3, 1'b0, 1'b0, 0);

        for (int i = 0; i < 14; i++) begin
            d  = $urandom_range(1, WD ? 26 : 30);
            st = 1'($urandom_range(0, 1));
            ms = (d > 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_once(d, st, ms, 0);
        end

        repeat (3) @(negedge clk);
        check("req_queue_drained", req_q.size(), 0);
        check("result_queue_drained", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
